// File: rtl/lvds_tx_pkg.sv
// rtl/lvds_tx_pkg.sv - shared types, constants and helpers for the LVDS transmit controller
//
// Contents:
//   tx_state_e : controller state (DISABLED, SYNC, STREAM, DRAIN)
//   WORD_CNT_W : width of the transmitted-word counter
//   clog2()    : counter width helper, never returns less than 1 bit

package lvds_tx_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DRAIN    = 2'd3
    } tx_state_e;

    localparam int WORD_CNT_W = 16;

    // Bits needed to count 0..value-1. A minimum of 1 keeps counters legal
    // when value is 1 (e.g. CLK_DIV=1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lvds_tx_ctrl_if.sv
// rtl/lvds_tx_ctrl_if.sv - word handshake and serial output bundle of the LVDS transmit controller
//
// Signals:
//   ENABLE, DATA, DATA_VALID : producer -> controller
//   DATA_READY               : controller -> producer, holding register free
//   TX_OUT, TX_OE            : serial bit and driver enable for the output buffer
//   BUSY, WORD_CNT           : status
// Modports: master (producer/observer side), slave (controller side).

interface lvds_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                                ENABLE;
    logic [DATA_WIDTH-1:0]               DATA;
    logic                                DATA_VALID;
    logic                                DATA_READY;
    logic                                TX_OUT;
    logic                                TX_OE;
    logic                                BUSY;
    logic [lvds_tx_pkg::WORD_CNT_W-1:0]  WORD_CNT;

    modport master (
        output ENABLE, DATA, DATA_VALID,
        input  DATA_READY, TX_OUT, TX_OE, BUSY, WORD_CNT
    );

    modport slave (
        input  ENABLE, DATA, DATA_VALID,
        output DATA_READY, TX_OUT, TX_OE, BUSY, WORD_CNT
    );

endinterface

// File: rtl/lvds_tx_bit_tick.sv
// rtl/lvds_tx_bit_tick.sv - serial bit prescaler, one tick per CLK_DIV clock cycles
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   clr      : synchronous clear, holds the prescaler at 0 and masks the tick
//   bit_tick : high in the last cycle of each serial bit period

module lvds_tx_bit_tick
    import lvds_tx_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int               CNT_W = clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/lvds_tx_ctrl.sv
// rtl/lvds_tx_ctrl.sv - LVDS transmit controller: preamble, MSB-first serialiser, fill and drain
//
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : lvds_tx_ctrl_if.slave (ENABLE/DATA/DATA_VALID in; DATA_READY,
//         TX_OUT, TX_OE, BUSY, WORD_CNT out)
// A one-deep holding register sits in front of the shift register. Each enable
// session starts with SYNC_REPEAT sync words; idle word slots are filled with
// SYNC_WORD so the link never goes quiet while enabled.

module lvds_tx_ctrl
    import lvds_tx_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CLK_DIV     = 1,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = DATA_WIDTH'(8'hBC),
    parameter int                    SYNC_REPEAT = 4
) (
    input  logic         CLK,
    input  logic         RST,
    lvds_tx_ctrl_if.slave bus
);

    localparam int                BIT_W     = clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam int                SYNC_W    = clog2(SYNC_REPEAT + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_REPEAT);

    tx_state_e               state_q,     state_d;
    logic [DATA_WIDTH-1:0]   shift_q,     shift_d;
    logic [BIT_W-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q,      hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    is_data_q,   is_data_d;
    logic [SYNC_W-1:0]       sync_cnt_q,  sync_cnt_d;
    logic                    tx_oe_q,     tx_oe_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q,  word_cnt_d;

    logic bit_tick;
    logic word_end;
    logic data_ready;
    logic accept;
    logic load_hold;
    logic load_sync;
    logic go_off;

    lvds_tx_bit_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_tick (
        .clk      (CLK),
        .rst      (RST),
        .clr      (state_q == ST_DISABLED),
        .bit_tick (bit_tick)
    );

    // Word boundary: the tick that ends the LSB of the word in the shifter.
    assign word_end   = bit_tick && (bit_cnt_q == LAST_BIT);
    assign data_ready = !hold_full_q && ((state_q == ST_SYNC) || (state_q == ST_STREAM));
    assign accept     = bus.DATA_VALID && data_ready;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        is_data_d   = is_data_q;
        sync_cnt_d  = sync_cnt_q;
        tx_oe_d     = tx_oe_q;
        word_cnt_d  = word_cnt_q;
        load_hold   = 1'b0;
        load_sync   = 1'b0;
        go_off      = 1'b0;

        case (state_q)
            ST_DISABLED: begin
                if (bus.ENABLE) begin
                    state_d    = ST_SYNC;
                    shift_d    = SYNC_WORD;
                    bit_cnt_d  = '0;
                    is_data_d  = 1'b0;
                    sync_cnt_d = SYNC_W'(1);
                    tx_oe_d    = 1'b1;
                end
            end
            ST_SYNC, ST_STREAM: begin
                if (word_end) begin
                    if (!bus.ENABLE) begin
                        // A held word is still owed to the link; send it before stopping.
                        if (hold_full_q) begin
                            load_hold = 1'b1;
                            state_d   = ST_DRAIN;
                        end else begin
                            go_off = 1'b1;
                        end
                    end else if ((state_q == ST_SYNC) && (sync_cnt_q < SYNC_LAST)) begin
                        load_sync  = 1'b1;
                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                    end else begin
                        state_d = ST_STREAM;
                        if (hold_full_q) begin
                            load_hold = 1'b1;
                        end else begin
                            load_sync = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (word_end) begin
                    go_off = 1'b1;
                end
            end
            default: begin
                go_off = 1'b1;
            end
        endcase

        if (bit_tick && !word_end) begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end

        // Only real data words count, and only once their last bit is out.
        if (word_end && is_data_q) begin
            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
        end

        if (load_hold) begin
            shift_d     = hold_q;
            is_data_d   = 1'b1;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
        end

        if (load_sync) begin
            shift_d   = SYNC_WORD;
            is_data_d = 1'b0;
            bit_cnt_d = '0;
        end

        if (go_off) begin
            state_d   = ST_DISABLED;
            shift_d   = '0;
            tx_oe_d   = 1'b0;
            is_data_d = 1'b0;
            bit_cnt_d = '0;
        end

        // A word accepted while the shifter reloads from an empty holding
        // register lands in the holding register; the current slot gets fill.
        if (accept) begin
            hold_d      = bus.DATA;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_DISABLED;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            is_data_q   <= 1'b0;
            sync_cnt_q  <= '0;
            tx_oe_q     <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            is_data_q   <= is_data_d;
            sync_cnt_q  <= sync_cnt_d;
            tx_oe_q     <= tx_oe_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // TX_OUT is the shifter MSB, itself a flop; the shifter is zero while disabled.
    assign bus.TX_OUT     = shift_q[DATA_WIDTH-1];
    assign bus.TX_OE      = tx_oe_q;
    assign bus.BUSY       = (state_q != ST_DISABLED);
    assign bus.DATA_READY = data_ready;
    assign bus.WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_lvds_tx_ctrl.sv
// tb/tb_lvds_tx_ctrl.sv - self-checking bench for lvds_tx_ctrl at CLK_DIV 1 and 3

module tb_lvds_tx_ctrl;

    localparam int        DW   = 8;
    localparam logic [7:0] SYNC = 8'hBC;
    localparam int        SR   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lvds_tx_ctrl_if #(.DATA_WIDTH(DW)) bus0 ();
    lvds_tx_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();

    lvds_tx_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(1), .SYNC_WORD(SYNC), .SYNC_REPEAT(SR))
        dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    lvds_tx_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(3), .SYNC_WORD(SYNC), .SYNC_REPEAT(SR))
        dut1 (.CLK(clk), .RST(rst), .bus(bus1));

    logic       en = 1'b0;
    logic       vld [2];
    logic [7:0] dat [2];
    logic       o_rdy [2];
    logic       o_tx [2];
    logic       o_oe [2];
    logic       o_busy [2];
    logic [15:0] o_cnt [2];

    assign bus0.ENABLE = en;           assign bus1.ENABLE = en;
    assign bus0.DATA = dat[0];         assign bus1.DATA = dat[1];
    assign bus0.DATA_VALID = vld[0];   assign bus1.DATA_VALID = vld[1];
    assign o_rdy[0] = bus0.DATA_READY; assign o_rdy[1] = bus1.DATA_READY;
    assign o_tx[0] = bus0.TX_OUT;      assign o_tx[1] = bus1.TX_OUT;
    assign o_oe[0] = bus0.TX_OE;       assign o_oe[1] = bus1.TX_OE;
    assign o_busy[0] = bus0.BUSY;      assign o_busy[1] = bus1.BUSY;
    assign o_cnt[0] = bus0.WORD_CNT;   assign o_cnt[1] = bus1.WORD_CNT;

    // Reference model: the link as a sequence of whole words, each sent
    // MSB-first for cd[i] cycles per bit, with a one-word waiting slot.
    int cd [2] = '{1, 3};
    bit m_on [2];      // link driven
    bit m_drain [2];   // stopping after the current word
    bit m_data [2];    // current word is producer data
    bit m_hv [2];      // waiting word present
    int m_word [2];
    int m_pos [2];     // bit index being sent, 0 = MSB
    int m_sub [2];     // cycle within the bit
    int m_pre [2];     // preamble words still owed after the current one
    int m_hold [2];
    int m_cnt [2];

    int  mode [2];     // 0 = directed queue, 1 = random
    bit  acc_prev [2];
    int  dq0 [$];
    int  dq1 [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int i);
        return m_on[i] && !m_drain[i] && !m_hv[i];
    endfunction

    function automatic bit m_txbit(input int i);
        if (!m_on[i]) return 1'b0;
        return 1'((m_word[i] >> (DW - 1 - m_pos[i])) & 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_on[i] = 0; m_drain[i] = 0; m_data[i] = 0; m_hv[i] = 0;
            m_word[i] = 0; m_pos[i] = 0; m_sub[i] = 0; m_pre[i] = 0;
            m_hold[i] = 0; m_cnt[i] = 0; acc_prev[i] = 0;
        end
    endtask

    task automatic compare(input int i);
        chk($sformatf("i%0d tx_oe", i),      32'(o_oe[i]),   32'(m_on[i]));
        chk($sformatf("i%0d tx_out", i),     32'(o_tx[i]),   32'(m_txbit(i)));
        chk($sformatf("i%0d busy", i),       32'(o_busy[i]), 32'(m_on[i]));
        chk($sformatf("i%0d data_ready", i), 32'(o_rdy[i]),  32'(m_ready(i)));
        chk($sformatf("i%0d word_cnt", i),   32'(o_cnt[i]),  32'(m_cnt[i]));
    endtask

    // Advance the model across one rising edge.
    task automatic advance(input int i, input bit acc);
        if (!m_on[i]) begin
            if (en) begin
                m_on[i] = 1; m_drain[i] = 0; m_word[i] = SYNC; m_data[i] = 0;
                m_pos[i] = 0; m_sub[i] = 0; m_pre[i] = SR - 1;
            end
        end else if (m_sub[i] < cd[i] - 1) begin
            m_sub[i]++;
        end else begin
            m_sub[i] = 0;
            if (m_pos[i] < DW - 1) begin
                m_pos[i]++;
            end else begin
                m_pos[i] = 0;
                if (m_data[i]) m_cnt[i] = (m_cnt[i] + 1) & 16'hFFFF;
                if (m_drain[i]) begin
                    m_on[i] = 0;
                end else if (!en) begin
                    if (m_hv[i]) begin
                        m_word[i] = m_hold[i]; m_data[i] = 1; m_hv[i] = 0; m_drain[i] = 1;
                    end else begin
                        m_on[i] = 0;
                    end
                end else if (m_pre[i] > 0) begin
                    m_word[i] = SYNC; m_data[i] = 0; m_pre[i]--;
                end else if (m_hv[i]) begin
                    m_word[i] = m_hold[i]; m_data[i] = 1; m_hv[i] = 0;
                end else begin
                    m_word[i] = SYNC; m_data[i] = 0;
                end
            end
        end
        if (acc) begin
            m_hold[i] = int'(dat[i]);
            m_hv[i]   = 1;
        end
    endtask

    // One clock: check outputs, update producers, predict the edge, move on.
    task automatic step();
        bit acc;
        for (int i = 0; i < 2; i++) compare(i);
        for (int i = 0; i < 2; i++) begin
            if (!(vld[i] && !acc_prev[i])) begin
                vld[i] = 1'b0;
                if (mode[i] == 1) begin
                    vld[i] = ($urandom_range(2) == 0);
                    dat[i] = 8'($urandom);
                end else if (i == 0 && dq0.size() > 0) begin
                    vld[i] = 1'b1; dat[i] = 8'(dq0.pop_front());
                end else if (i == 1 && dq1.size() > 0) begin
                    vld[i] = 1'b1; dat[i] = 8'(dq1.pop_front());
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            acc = vld[i] && m_ready(i);
            advance(i, acc);
            acc_prev[i] = acc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        vld[0] = 0; vld[1] = 0; dat[0] = 0; dat[1] = 0;
        mode[0] = 0; mode[1] = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare(i);
        rst = 1'b0;

        // Preamble, then one word pushed three edges after enable.
        en = 1'b1;
        steps(3);
        dq0.push_back(8'hA5); dq1.push_back(8'hA5);
        steps(40);
        chk("a5 word_cnt i0", 32'(o_cnt[0]), 32'd1);

        // Back-to-back stream of 16 words.
        for (int v = 1; v <= 16; v++) begin
            dq0.push_back(v); dq1.push_back(v);
        end
        steps(160);
        chk("stream word_cnt i0", 32'(o_cnt[0]), 32'd17);
        steps(300);
        chk("stream word_cnt i1", 32'(o_cnt[1]), 32'd17);

        // Disable with one word in flight and one waiting.
        dq0.push_back(8'h3C); dq0.push_back(8'hF0);
        dq1.push_back(8'h3C); dq1.push_back(8'hF0);
        steps(30);
        en = 1'b0;
        steps(100);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("drain busy i%0d", i),     32'(o_busy[i]), 32'd0);
            chk($sformatf("drain tx_oe i%0d", i),    32'(o_oe[i]),   32'd0);
            chk($sformatf("drain word_cnt i%0d", i), 32'(o_cnt[i]),  32'd19);
        end

        // Asynchronous reset between edges, then a fresh session.
        en = 1'b1;
        steps(25);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst tx_out i%0d", i),     32'(o_tx[i]),  32'd0);
            chk($sformatf("rst tx_oe i%0d", i),      32'(o_oe[i]),  32'd0);
            chk($sformatf("rst data_ready i%0d", i), 32'(o_rdy[i]), 32'd0);
            chk($sformatf("rst word_cnt i%0d", i),   32'(o_cnt[i]), 32'd0);
        end
        model_reset();
        vld[0] = 0; vld[1] = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        steps(80);

        // Random traffic with enable toggling at random points.
        mode[0] = 1; mode[1] = 1;
        for (int r = 0; r < 14; r++) begin
            en = 1'($urandom_range(1));
            if (r < 2) en = 1'b1;
            steps($urandom_range(20, 250));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lvds_tx_ctrl.md
Name: lvds_tx_ctrl

Overview:
Serial transmit controller that sequences a differential output buffer's single-ended input (I) and drives its output enable.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first.
- Prefixes each enable session with a sync preamble and fills gaps with the sync word, so the link never goes quiet while enabled.
- Drains cleanly on disable.

Parameters:
- DATA_WIDTH, 8, serial word width in bits (≥2).
- CLK_DIV, 1, CLK cycles per serial bit (≥1).
- SYNC_WORD, 8'hBC, preamble/fill word, DATA_WIDTH bits.
- SYNC_REPEAT, 4, preamble length in words (≥1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  level; start/stop transmission.
- DATA  in  DATA_WIDTH  word to transmit.
- DATA_VALID  in  1  DATA is valid.
- DATA_READY  out  1  holding register can accept a word.
- TX_OUT  out  1  serial bit, registered; connects to buffer input I.
- TX_OE  out  1  buffer/driver enable, registered.
- BUSY  out  1  state != DISABLED.
- WORD_CNT  out  16  count of DATA words fully transmitted (fill/sync not counted); wraps 16'hFFFF->0.

Behaviour:
- Reset (async, immediate):
  - Outputs: TX_OUT=0, TX_OE=0, DATA_READY=0, BUSY=0, WORD_CNT=0.
  - Internal: holding register empty, prescaler=0, bit counter=0, state=DISABLED.
- Bit timing: prescaler counts 0..CLK_DIV-1. bit_tick=1 when prescaler==CLK_DIV-1. Each bit is held exactly CLK_DIV cycles. A word boundary is the bit_tick of bit index 0 (LSB).
- Holding register (1 deep):
  - DATA_READY = !hold_full && state in {SYNC, STREAM}.
  - Word accepted when DATA_VALID && DATA_READY on a rising edge.
  - Holding register and shift register may both be full.
- States:
  - DISABLED:
    - TX_OE=0, TX_OUT=0.
    - If ENABLE sampled 1 at edge n: go to SYNC; load SYNC_WORD; at n+1 TX_OE=1 and TX_OUT=SYNC_WORD MSB; sync_cnt=1.
  - SYNC:
    - Transmit SYNC_WORD back-to-back.
    - At each word boundary: if sync_cnt<SYNC_REPEAT, reload SYNC_WORD and increment sync_cnt; else go to STREAM and load per the STREAM rule in the same edge.
    - The holding register may be filled during SYNC.
  - STREAM:
    - At each word boundary, load the holding register if full (clear hold_full; WORD_CNT increments when that word's last bit completes), else load SYNC_WORD as fill.
    - Words are back-to-back with no idle bit.
  - DRAIN:
    - Entered at the word boundary following ENABLE=0 (checked at every word boundary in SYNC/STREAM).
    - The current word always completes.
    - If hold_full, the held word is transmitted next (no data loss).
    - After the last word's final bit: DISABLED; TX_OE=0, TX_OUT=0 on the following edge.
- Simultaneous events:
  - Word accepted on the same edge the shift register reloads from an empty holding register: the new word goes to the holding register, not the shift register. Fill is sent for that word slot.
  - ENABLE toggling within a word has no effect until the boundary.
  - ENABLE=1 during DRAIN is ignored; DISABLED re-evaluates ENABLE on the next edge, giving a fresh preamble.
- DATA_VALID while DATA_READY=0 is ignored; the producer holds DATA.
- Latency: a word accepted into an empty holding register in STREAM starts on TX_OUT at most DATA_WIDTH·CLK_DIV+1 cycles later.

Decomposition:
- Shared package lvds_tx_pkg:
  - state enum (DISABLED, SYNC, STREAM, DRAIN).
  - Counter width function clog2.
  - WORD_CNT width constant (16).
- One sub-module: lvds_tx_bit_tick. CLK_DIV prescaler with async RST and sync clear; outputs bit_tick.

Test Plan:
(all at DATA_WIDTH=8, SYNC_WORD=8'hBC, SYNC_REPEAT=2, CLK_DIV=1 unless noted)
- ENABLE=1 at edge n, no data:
  - TX_OE=1 from n+1.
  - TX_OUT = 10111100 repeated indefinitely.
  - WORD_CNT=0, DATA_READY=1 from n+1.
- Push 8'hA5 at n+3 (during preamble):
  - Exactly 16 sync bits, then 10100101, then 10111100 fill.
  - WORD_CNT=1 after bit 24.
  - DATA_READY low from n+4 until the A5 load.
- Continuous DATA_VALID with 8'h01..8'h10 in STREAM:
  - 128 contiguous data bits, no fill between words.
  - WORD_CNT=16.
  - DATA_READY pulses once per 8 cycles.
- ENABLE=0 at bit 3 of word 8'h3C with 8'hF0 held:
  - 3C completes, F0 follows.
  - Then TX_OE=0, TX_OUT=0, BUSY=0.
  - WORD_CNT +2.
- CLK_DIV=3: each TX_OUT bit is stable exactly 3 cycles; preamble lasts 48 cycles.
- RST pulsed mid-word (asynchronous, between edges): TX_OE, TX_OUT, WORD_CNT, DATA_READY go 0 immediately. After release with ENABLE=1, a full preamble restarts.
